// File: rtl/gpio_out_bank.sv
// gpio_out_bank: double-buffered GPIO output bank on a byte-wide bus.
// CPU writes land in per-byte shadow registers. They reach the live
// registers, which drive the pins, in one of two ways:
//   - a CONTROL commit copies every shadow byte into live at once;
//   - with auto-commit on, each data write also updates its live byte.
// WRITE, SET and CLEAR give atomic bit manipulation of the shadow bytes.
//
// Bus handshake: a request is taken on every rising edge where read or
// write is high. ready_r / ready_w is high for exactly the following cycle
// (ready <= request), and data_out is valid in that same cycle. There is no
// back-pressure, so a new request may be issued every cycle. Reset wins
// over any request sampled on the same edge.
module gpio_out_bank #(
    parameter int size_addr = 2,
    parameter int size      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 write,
    input  logic [size_addr+1:0] address,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 ready_r,
    output logic                 ready_w,
    output logic [8*size-1:0]    gpio
);

    // Op codes held in the top two address bits. A write and a read
    // issued in the same cycle share this field.
    localparam logic [1:0] OP_WRITE   = 2'b00;  // read: shadow byte
    localparam logic [1:0] OP_SET     = 2'b01;  // read: live byte
    localparam logic [1:0] OP_CLEAR   = 2'b10;  // read: always zero
    localparam logic [1:0] OP_CONTROL = 2'b11;  // read: control register

    logic [1:0]           op;
    logic [size_addr-1:0] index;

    assign op    = address[size_addr+1:size_addr];
    assign index = address[size_addr-1:0];

    logic [7:0]      shadow [size];
    logic [7:0]      live   [size];
    logic            auto_commit;

    logic [size-1:0] hit;         // one-hot index decode, all zero if index >= size
    logic [7:0]      shadow_sel;  // addressed shadow byte, zero if out of range
    logic [7:0]      live_sel;    // addressed live byte, zero if out of range
    logic [7:0]      shadow_new;  // value a data write leaves in the shadow byte
    logic [7:0]      read_data;   // value returned by a read this cycle
    logic            data_wr;     // WRITE / SET / CLEAR in progress
    logic            ctrl_wr;     // CONTROL write in progress
    logic            commit;      // CONTROL write requesting shadow -> live copy

    assign data_wr = write && (op != OP_CONTROL);
    assign ctrl_wr = write && (op == OP_CONTROL);
    assign commit  = ctrl_wr && data_in[0];

    // Index decode. Indices at or above size match no byte, so an
    // out-of-range write changes nothing and an out-of-range read sees zero.
    always_comb begin
        hit = '0;
        for (int i = 0; i < size; i++) begin
            hit[i] = (int'(index) == i);
        end
    end

    // Select the addressed shadow and live bytes (pre-edge values).
    always_comb begin
        shadow_sel = '0;
        live_sel   = '0;
        for (int i = 0; i < size; i++) begin
            if (hit[i]) begin
                shadow_sel = shadow[i];
                live_sel   = live[i];
            end
        end
    end

    // New shadow value for a data write; SET and CLEAR modify the current
    // byte, so no read-modify-write is needed from the CPU.
    always_comb begin
        shadow_new = data_in;
        case (op)
            OP_SET:   shadow_new = shadow_sel | data_in;
            OP_CLEAR: shadow_new = shadow_sel & ~data_in;
            default:  shadow_new = data_in;
        endcase
    end

    // Read mux. Built only from pre-edge state, which gives read-before-write
    // behaviour when a read and a write (including a commit) coincide.
    // The control register ignores the index field.
    always_comb begin
        read_data = '0;
        case (op)
            OP_WRITE:   read_data = shadow_sel;
            OP_SET:     read_data = live_sel;
            OP_CLEAR:   read_data = '0;
            OP_CONTROL: read_data = {6'b0, auto_commit, 1'b0};
            default:    read_data = '0;
        endcase
    end

    // Handshake pulses and registered read data. data_out holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r  <= 1'b0;
            ready_w  <= 1'b0;
            data_out <= '0;
        end else begin
            ready_r <= read;
            ready_w <= write;
            if (read) begin
                data_out <= read_data;
            end
        end
    end

    // Control register: auto-commit enable, written by every CONTROL write.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_commit <= 1'b0;
        end else if (ctrl_wr) begin
            auto_commit <= data_in[1];
        end
    end

    // Shadow registers: updated only by data writes to an in-range index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < size; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                if (data_wr && hit[i]) begin
                    shadow[i] <= shadow_new;
                end
            end
        end
    end

    // Live registers: a commit copies all pre-edge shadow bytes; otherwise
    // an auto-commit data write mirrors its new shadow value. A commit is a
    // CONTROL write, so the two cases never occur on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < size; i++) begin
                live[i] <= '0;
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                if (commit) begin
                    live[i] <= shadow[i];
                end else if (data_wr && auto_commit && hit[i]) begin
                    live[i] <= shadow_new;
                end
            end
        end
    end

    // Pins come straight from the live flops, so bus activity cannot glitch them.
    always_comb begin
        gpio = '0;
        for (int i = 0; i < size; i++) begin
            gpio[8*i +: 8] = live[i];
        end
    end

endmodule

// File: tb/tb_gpio_out_bank.sv
// tb_gpio_out_bank: two banks (size 4 and size 3, both with a 2-bit index)
// share one bus, so index 3 is a real byte in one and out of range in the
// other. A per-byte array model predicts every output after each edge.
module tb_gpio_out_bank;

    // ---------------- clock / reset / bus ----------------
    logic clk = 1'b0;
    logic reset;
    logic read;
    logic write;
    logic [3:0] address;
    logic [7:0] data_in;

    always #5 clk = ~clk;

    logic [7:0]  dout4, dout3;
    logic        rr4, rw4, rr3, rw3;
    logic [31:0] gpio4;
    logic [23:0] gpio3;

    gpio_out_bank #(.size_addr(2), .size(4)) dut4 (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .address(address), .data_in(data_in),
        .data_out(dout4), .ready_r(rr4), .ready_w(rw4), .gpio(gpio4)
    );

    gpio_out_bank #(.size_addr(2), .size(3)) dut3 (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .address(address), .data_in(data_in),
        .data_out(dout3), .ready_r(rr3), .ready_w(rw3), .gpio(gpio3)
    );

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- behavioural model ----------------
    // Index 0 models the size-4 bank, index 1 the size-3 bank.
    int         sz [2] = '{4, 3};
    logic [7:0] m_sh [2][4];
    logic [7:0] m_lv [2][4];
    logic [7:0] m_do [2];
    logic       m_ac [2];
    logic       m_rr;
    logic       m_rw;

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 4; k++) begin
                m_sh[u][k] = 8'h00;
                m_lv[u][k] = 8'h00;
            end
            m_do[u] = 8'h00;
            m_ac[u] = 1'b0;
        end
        m_rr = 1'b0;
        m_rw = 1'b0;
    endtask

    // Expected state after the coming edge, computed from the current one.
    task automatic model_step(input logic rst, input logic rd, input logic wr,
                              input logic [3:0] a, input logic [7:0] d);
        int op;
        int idx;
        logic [7:0] nv;
        op  = int'(a[3:2]);
        idx = int'(a[1:0]);
        if (rst) begin
            model_reset();
        end else begin
            m_rr = rd;
            m_rw = wr;
            for (int u = 0; u < 2; u++) begin
                if (rd) begin
                    if (op == 3)
                        m_do[u] = {6'b0, m_ac[u], 1'b0};
                    else if (op == 2 || idx >= sz[u])
                        m_do[u] = 8'h00;
                    else if (op == 0)
                        m_do[u] = m_sh[u][idx];
                    else
                        m_do[u] = m_lv[u][idx];
                end
                if (wr) begin
                    if (op == 3) begin
                        if (d[0]) begin
                            for (int k = 0; k < sz[u]; k++) m_lv[u][k] = m_sh[u][k];
                        end
                        m_ac[u] = d[1];
                    end else if (idx < sz[u]) begin
                        if (op == 0)      nv = d;
                        else if (op == 1) nv = m_sh[u][idx] | d;
                        else              nv = m_sh[u][idx] & ~d;
                        m_sh[u][idx] = nv;
                        if (m_ac[u]) m_lv[u][idx] = nv;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_gpio(input int u);
        logic [31:0] g;
        g = '0;
        for (int k = 0; k < sz[u]; k++) g[8*k +: 8] = m_lv[u][k];
        return g;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both banks against the model.
    always @(posedge clk) begin
        logic [31:0] g4;
        logic [31:0] g3;
        #2;
        if (chk_en) begin
            g4 = exp_gpio(0);
            g3 = exp_gpio(1);
            check("cyc_dout4", {24'b0, dout4}, {24'b0, m_do[0]});
            check("cyc_rr4",   {31'b0, rr4},   {31'b0, m_rr});
            check("cyc_rw4",   {31'b0, rw4},   {31'b0, m_rw});
            check("cyc_gpio4", gpio4,          g4);
            check("cyc_dout3", {24'b0, dout3}, {24'b0, m_do[1]});
            check("cyc_rr3",   {31'b0, rr3},   {31'b0, m_rr});
            check("cyc_rw3",   {31'b0, rw3},   {31'b0, m_rw});
            check("cyc_gpio3", {8'b0, gpio3},  {8'b0, g3[23:0]});
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic rst, input logic rd, input logic wr,
                         input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        reset   = rst;
        read    = rd;
        write   = wr;
        address = a;
        data_in = d;
        model_step(rst, rd, wr, a, d);
        @(posedge clk);
    endtask

    // {read, write, address[3:0], data_in[7:0]}
    logic [13:0] vec [8] = '{
        {1'b1, 1'b1, 4'b0001, 8'hC3},
        {1'b1, 1'b0, 4'b0101, 8'h00},
        {1'b0, 1'b1, 4'b1100, 8'h01},
        {1'b1, 1'b1, 4'b1010, 8'hFF},
        {1'b1, 1'b1, 4'b0110, 8'h00},
        {1'b1, 1'b0, 4'b0010, 8'h00},
        {1'b0, 1'b1, 4'b1100, 8'h01},
        {1'b1, 1'b0, 4'b0110, 8'h00}
    };

    // ---------------- stimulus ----------------
    initial begin
        logic [13:0] v;
        logic [3:0]  a;
        reset   = 1'b1;
        read    = 1'b0;
        write   = 1'b0;
        address = '0;
        data_in = '0;
        model_reset();

        cycle(1, 0, 0, 4'h0, 8'h00);
        chk_en = 1'b1;
        cycle(1, 0, 0, 4'h0, 8'h00);
        #2 check("rst_gpio4", gpio4, 32'h0);
        check("rst_ready_r", {31'b0, rr4}, 32'h0);

        // Reads straight after reset
        cycle(0, 1, 0, 4'b0000, 8'h00);
        #2 check("rd_shadow0_rdy", {31'b0, rr4}, 32'h1);
        check("rd_shadow0_data", {24'b0, dout4}, 32'h0);
        cycle(0, 1, 0, 4'b0100, 8'h00);
        #2 check("rd_live0_data", {24'b0, dout4}, 32'h0);
        cycle(0, 1, 0, 4'b1100, 8'h00);
        #2 check("rd_ctrl_data", {24'b0, dout4}, 32'h0);
        cycle(0, 0, 0, 4'b0000, 8'h00);
        #2 check("rd_idle_rdy", {31'b0, rr4}, 32'h0);

        // WRITE without auto-commit, then commit
        cycle(0, 0, 1, 4'b0010, 8'hA5);
        #2 check("wr_a5_gpio_hold", gpio4, 32'h0);
        check("wr_a5_ready_w", {31'b0, rw4}, 32'h1);
        cycle(0, 1, 0, 4'b0010, 8'h00);
        #2 check("rd_shadow2", {24'b0, dout4}, 32'hA5);
        cycle(0, 1, 0, 4'b0110, 8'h00);
        #2 check("rd_live2", {24'b0, dout4}, 32'h00);
        cycle(0, 0, 1, 4'b1100, 8'h01);
        #2 check("commit_gpio4", gpio4, 32'h00A5_0000);
        check("commit_gpio3", {8'b0, gpio3}, 32'h00A5_0000);

        // SET / CLEAR on byte 1
        cycle(0, 0, 1, 4'b0001, 8'h30);
        cycle(0, 0, 1, 4'b0101, 8'h0F);
        cycle(0, 0, 1, 4'b1001, 8'h05);
        cycle(0, 1, 0, 4'b0001, 8'h00);
        #2 check("set_clear_shadow1", {24'b0, dout4}, 32'h3A);

        // Auto-commit on, write byte 3 (out of range for the size-3 bank)
        cycle(0, 0, 1, 4'b1100, 8'h02);
        cycle(0, 0, 1, 4'b0011, 8'h77);
        #2 check("auto_gpio4", gpio4, 32'h77A5_0000);
        check("auto_gpio3", {8'b0, gpio3}, 32'h00A5_0000);
        cycle(0, 1, 0, 4'b1100, 8'h00);
        #2 check("ctrl_read", {24'b0, dout4}, 32'h02);

        // Same-cycle read + commit: read sees pre-edge control value
        cycle(0, 0, 1, 4'b1100, 8'h00);
        cycle(0, 0, 1, 4'b0000, 8'hFF);
        cycle(0, 1, 1, 4'b1100, 8'h03);
        #2 check("rw_commit_data", {24'b0, dout4}, 32'h00);
        check("rw_commit_rr", {31'b0, rr4}, 32'h1);
        check("rw_commit_rw", {31'b0, rw4}, 32'h1);
        check("rw_commit_gpio4", gpio4, 32'h77A5_3AFF);
        check("rw_commit_gpio3", {8'b0, gpio3}, 32'h00A5_3AFF);

        // Same-cycle read of live and auto-commit SET: read sees pre-edge live
        cycle(0, 0, 1, 4'b1000, 8'hFF);
        cycle(0, 1, 1, 4'b0100, 8'h0F);
        #2 check("rw_live_data", {24'b0, dout4}, 32'h00);
        check("rw_live_gpio4", gpio4, 32'h77A5_3A0F);

        // Out-of-range index on the size-3 bank
        cycle(0, 0, 1, 4'b0011, 8'h55);
        #2 check("oor_wr_gpio3", {8'b0, gpio3}, 32'h00A5_3A0F);
        check("oor_wr_ready_w", {31'b0, rw3}, 32'h1);
        check("inr_wr_gpio4", gpio4, 32'h55A5_3A0F);
        cycle(0, 1, 0, 4'b0011, 8'h00);
        #2 check("oor_rd_dout3", {24'b0, dout3}, 32'h00);
        check("inr_rd_dout4", {24'b0, dout4}, 32'h55);
        cycle(0, 1, 0, 4'b1001, 8'h00);
        #2 check("rd_op10_zero", {24'b0, dout4}, 32'h00);

        // Mixed directed vectors, checked by the model every cycle
        for (int i = 0; i < 8; i++) begin
            v = vec[i];
            cycle(0, v[13], v[12], v[11:8], v[7:0]);
        end

        // Continuous writes with a one-cycle reset in the middle
        for (int i = 0; i < 6; i++) begin
            a = 4'(i % 3);
            cycle((i == 3) ? 1'b1 : 1'b0, 0, 1, a, 8'(8'h11 * (i + 1)));
            if (i == 3) begin
                #2 check("mid_rst_ready_w", {31'b0, rw4}, 32'h0);
                check("mid_rst_gpio4", gpio4, 32'h0);
                check("mid_rst_gpio3", {8'b0, gpio3}, 32'h0);
            end
            if (i == 4) begin
                #2 check("post_rst_ready_w", {31'b0, rw4}, 32'h1);
            end
        end

        cycle(0, 0, 0, 4'h0, 8'h00);
        cycle(0, 0, 0, 4'h0, 8'h00);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
